// File: rtl/regfile_writeback_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_writeback_ctrl_pkg
// Description : Shared widths, register-zero constant and writeback entry
//               layout for the register-file write-side controller.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_writeback_ctrl_pkg;

  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 32;

  localparam logic [ADDR_WIDTH-1:0] REG_ZERO = 5'd0;

  // One buffered writeback: a cleared live bit means the write is dropped at issue.
  typedef struct packed {
    logic                  live;
    logic [ADDR_WIDTH-1:0] wreg;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/regfile_writeback_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_writeback_ctrl_if
// Description : Writeback sources, register-file write port and read-port
//               forwarding signals of the write-side controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_writeback_ctrl_if
  import regfile_writeback_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = regfile_writeback_ctrl_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_writeback_ctrl_pkg::ADDR_WIDTH
);

  logic                         wb_a_valid;
  logic [ADDR_WIDTH-1:0]        wb_a_reg;
  logic [DATA_WIDTH-1:0]        wb_a_data;

  logic                         wb_b_valid;
  logic                         wb_b_ready;
  logic [ADDR_WIDTH-1:0]        wb_b_reg;
  logic [DATA_WIDTH-1:0]        wb_b_data;

  logic                         ctrl_writeEnable;
  logic [ADDR_WIDTH-1:0]        ctrl_writeReg;
  logic [DATA_WIDTH-1:0]        data_writeReg;

  logic [ADDR_WIDTH-1:0]        ctrl_readRegA;
  logic [ADDR_WIDTH-1:0]        ctrl_readRegB;
  logic [DATA_WIDTH-1:0]        rf_readRegA;
  logic [DATA_WIDTH-1:0]        rf_readRegB;
  logic [DATA_WIDTH-1:0]        data_readRegA;
  logic [DATA_WIDTH-1:0]        data_readRegB;

  logic [(1<<ADDR_WIDTH)-1:0]   pending_mask;

  // Pipeline / mult-div / regfile side
  modport master (
    output wb_a_valid, wb_a_reg, wb_a_data,
    output wb_b_valid, wb_b_reg, wb_b_data,
    input  wb_b_ready,
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    output ctrl_readRegA, ctrl_readRegB, rf_readRegA, rf_readRegB,
    input  data_readRegA, data_readRegB,
    input  pending_mask
  );

  // Controller side
  modport slave (
    input  wb_a_valid, wb_a_reg, wb_a_data,
    input  wb_b_valid, wb_b_reg, wb_b_data,
    output wb_b_ready,
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    input  ctrl_readRegA, ctrl_readRegB, rf_readRegA, rf_readRegB,
    output data_readRegA, data_readRegB,
    output pending_mask
  );

endinterface
`default_nettype wire

// File: rtl/regfile_writeback_ctrl_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Circular buffer of B-source writebacks with per-entry live
//               bits that can be cleared by register number (WAW kill).
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
  import regfile_writeback_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_WIDTH = regfile_writeback_ctrl_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_writeback_ctrl_pkg::ADDR_WIDTH
) (
  input  logic                                  clock,
  input  logic                                  ctrl_reset,
  input  logic                                  push_en,
  input  logic [ADDR_WIDTH-1:0]                 push_reg,
  input  logic [DATA_WIDTH-1:0]                 push_data,
  input  logic                                  push_live,
  input  logic                                  pop_en,
  input  logic                                  kill_en,
  input  logic [ADDR_WIDTH-1:0]                 kill_reg,
  output logic                                  full,
  output logic                                  empty,
  output logic [ADDR_WIDTH-1:0]                 head_reg,
  output logic [DATA_WIDTH-1:0]                 head_data,
  output logic                                  head_live,
  output logic [FIFO_DEPTH-1:0][ADDR_WIDTH-1:0] entry_reg,
  output logic [FIFO_DEPTH-1:0]                 entry_live
);

  localparam int             PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  logic [PTR_W:0]                       wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]                       rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH-1:0][ADDR_WIDTH-1:0] reg_q, reg_d;
  logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] data_q, data_d;
  logic [FIFO_DEPTH-1:0]                live_q, live_d;

  logic [PTR_W-1:0] w_wr_idx;
  logic [PTR_W-1:0] w_rd_idx;
  logic             w_push;
  logic             w_pop;

  assign w_wr_idx = wr_ptr_q[PTR_W-1:0];
  assign w_rd_idx = rd_ptr_q[PTR_W-1:0];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  assign w_push = push_en && !full;
  assign w_pop  = pop_en && !empty;

  assign head_reg   = reg_q[w_rd_idx];
  assign head_data  = data_q[w_rd_idx];
  assign head_live  = live_q[w_rd_idx];
  assign entry_reg  = reg_q;
  assign entry_live = live_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    reg_d    = reg_q;
    data_d   = data_q;
    live_d   = live_q;

    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (kill_en && (reg_q[i] == kill_reg)) begin
        live_d[i] = 1'b0;
      end
    end

    // Popped slots drop their live bit so entry_live only reflects occupied slots.
    if (w_pop) begin
      live_d[w_rd_idx] = 1'b0;
      rd_ptr_d         = rd_ptr_q + PTR_ONE;
    end

    // A push on a kill edge counts as older than the killing write.
    if (w_push) begin
      reg_d[w_wr_idx]  = push_reg;
      data_d[w_wr_idx] = push_data;
      live_d[w_wr_idx] = push_live && !(kill_en && (push_reg == kill_reg));
      wr_ptr_d         = wr_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      reg_q    <= '0;
      data_q   <= '0;
      live_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      reg_q    <= reg_d;
      data_q   <= data_d;
      live_q   <= live_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_writeback_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : regfile_writeback_ctrl
// Description : Merges pipeline (A) and buffered mult/div (B) writebacks onto
//               the register-file write port and forwards colliding reads.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_writeback_ctrl
  import regfile_writeback_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_WIDTH = regfile_writeback_ctrl_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_writeback_ctrl_pkg::ADDR_WIDTH
) (
  input  logic                      clock,
  input  logic                      ctrl_reset,
  regfile_writeback_ctrl_if.slave   bus
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  logic                  write_en_q,   write_en_d;
  logic [ADDR_WIDTH-1:0] write_reg_q,  write_reg_d;
  logic [DATA_WIDTH-1:0] write_data_q, write_data_d;

  wb_entry_t                            w_b_entry;
  logic                                 w_a_live;
  logic                                 w_push;
  logic                                 w_pop;
  logic                                 w_full;
  logic                                 w_empty;
  logic [ADDR_WIDTH-1:0]                w_head_reg;
  logic [DATA_WIDTH-1:0]                w_head_data;
  logic                                 w_head_live;
  logic [FIFO_DEPTH-1:0][ADDR_WIDTH-1:0] w_entry_reg;
  logic [FIFO_DEPTH-1:0]                w_entry_live;
  logic [NUM_REGS-1:0]                  w_pending;
  logic                                 w_fwd_a;
  logic                                 w_fwd_b;

  assign w_b_entry = '{live: (bus.wb_b_reg != REG_ZERO),
                       wreg: bus.wb_b_reg,
                       data: bus.wb_b_data};

  assign w_a_live = bus.wb_a_valid && (bus.wb_a_reg != REG_ZERO);
  assign w_push   = bus.wb_b_valid && !w_full;
  // A has absolute priority; the head is only popped on edges without A.
  assign w_pop    = !bus.wb_a_valid && !w_empty;

  wb_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_wb_fifo (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .push_en    (w_push),
    .push_reg   (w_b_entry.wreg),
    .push_data  (w_b_entry.data),
    .push_live  (w_b_entry.live),
    .pop_en     (w_pop),
    .kill_en    (w_a_live),
    .kill_reg   (bus.wb_a_reg),
    .full       (w_full),
    .empty      (w_empty),
    .head_reg   (w_head_reg),
    .head_data  (w_head_data),
    .head_live  (w_head_live),
    .entry_reg  (w_entry_reg),
    .entry_live (w_entry_live)
  );

  always_comb begin
    write_en_d   = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (bus.wb_a_valid) begin
      if (w_a_live) begin
        write_en_d   = 1'b1;
        write_reg_d  = bus.wb_a_reg;
        write_data_d = bus.wb_a_data;
      end
    end else if (w_pop && w_head_live) begin
      write_en_d   = 1'b1;
      write_reg_d  = w_head_reg;
      write_data_d = w_head_data;
    end
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      write_en_q   <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      write_en_q   <= write_en_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  always_comb begin
    w_pending = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (w_entry_live[i]) begin
        w_pending[w_entry_reg[i]] = 1'b1;
      end
    end
  end

  // The regfile floats read data on a same-cycle write; substitute the write data.
  assign w_fwd_a = write_en_q && (write_reg_q == bus.ctrl_readRegA) && (write_reg_q != REG_ZERO);
  assign w_fwd_b = write_en_q && (write_reg_q == bus.ctrl_readRegB) && (write_reg_q != REG_ZERO);

  assign bus.data_readRegA    = w_fwd_a ? write_data_q : bus.rf_readRegA;
  assign bus.data_readRegB    = w_fwd_b ? write_data_q : bus.rf_readRegB;
  assign bus.wb_b_ready       = !w_full;
  assign bus.ctrl_writeEnable = write_en_q;
  assign bus.ctrl_writeReg    = write_reg_q;
  assign bus.data_writeReg    = write_data_q;
  assign bus.pending_mask     = w_pending;

endmodule
`default_nettype wire
